// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
// Operation encoding mirrors funct3 so decode can pass the field straight through.
package muldiv_sequencer_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } md_state_e;

   function automatic logic [XLEN-1:0] cond_neg32(input logic [XLEN-1:0] v, input logic neg);
      if (neg) begin
         cond_neg32 = ~v + 32'd1;
      end else begin
         cond_neg32 = v;
      end
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg64(input logic [2*XLEN-1:0] v, input logic neg);
      if (neg) begin
         cond_neg64 = ~v + 64'd1;
      end else begin
         cond_neg64 = v;
      end
   endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
// acc holds {hi, lo}; for multiply lo carries the remaining multiplier bits, for divide {remainder, dividend}.
module muldiv_step
   import muldiv_sequencer_pkg::*;
(
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   opb,
   output logic [2*XLEN-1:0] acc_next
);

   logic [XLEN:0] sum_s;
   logic [XLEN:0] shifted_s;
   logic [XLEN:0] diff_s;
   logic          no_borrow_s;

   // Both step flavours are formed every cycle; is_div picks which one advances acc.
   always_comb begin
      sum_s       = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
      shifted_s   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff_s      = shifted_s - {1'b0, opb};
      no_borrow_s = ~diff_s[XLEN];
      if (is_div) begin
         acc_next = {(no_borrow_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0]), acc[XLEN-2:0], no_borrow_s};
      end else begin
         acc_next = {sum_s, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M MUL/DIV/REM unit: 32 CALC steps, one FIXUP cycle, then a held DONE result.
// Optional MULDIV_EARLY_OUT_EN lets multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic [4:0]      req_wreg,
   input  logic            flush,
   output logic            busy,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic [4:0]      resp_wreg
);

   md_state_e         state_r, state_nx;
   md_op_e            op_r, op_nx, req_op_s;
   logic [4:0]        wreg_r, wreg_nx;
   logic              neg_r, neg_nx;
   logic [2*XLEN-1:0] acc_r, acc_nx;
   logic [XLEN-1:0]   opb_r, opb_nx;
   logic [CNT_W-1:0]  cnt_r, cnt_nx;
   logic              resp_valid_r, resp_valid_nx;
   logic [XLEN-1:0]   resp_data_r, resp_data_nx;
   logic [4:0]        resp_wreg_r, resp_wreg_nx;

   logic              a_signed_s, b_signed_s, sa_s, sb_s, neg_req_s;
   logic [XLEN-1:0]   abs_a_s, abs_b_s;
   logic              div_req_s, div_zero_s, div_ovf_s;
   logic [2*XLEN-1:0] step_acc_s, prod_s;
   logic [XLEN-1:0]   quo_rem_s, fix_data_s;
`ifdef MULDIV_EARLY_OUT_EN
   logic [5:0]        shamt_s;
   logic [XLEN-1:0]   rem_mask_s;
   logic              early_s;
`endif

   muldiv_step u_step (
      .is_div   (op_r[2]),
      .acc      (acc_r),
      .opb      (opb_r),
      .acc_next (step_acc_s)
   );

   assign req_ready  = (state_r == ST_IDLE) && !flush;
   assign busy       = (state_r != ST_IDLE);
   assign resp_valid = resp_valid_r;
   assign resp_data  = resp_data_r;
   assign resp_wreg  = resp_wreg_r;

   // Request decode: operand magnitudes, result sign and the single-cycle special cases.
   always_comb begin
      req_op_s = md_op_e'(req_op);
      case (req_op_s)
         MD_MULH:        begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         MD_MULHSU:      begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
         MD_DIV, MD_REM: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
      endcase
      sa_s       = a_signed_s & req_a[XLEN-1];
      sb_s       = b_signed_s & req_b[XLEN-1];
      abs_a_s    = cond_neg32(req_a, sa_s);
      abs_b_s    = cond_neg32(req_b, sb_s);
      neg_req_s  = (req_op[2] && req_op[1]) ? sa_s : (sa_s ^ sb_s);
      div_req_s  = req_op[2];
      div_zero_s = div_req_s && (req_b == 32'd0);
      div_ovf_s  = ((req_op_s == MD_DIV) || (req_op_s == MD_REM)) &&
                   (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
   end

   // Sign fix-up and word selection applied to the finished accumulator.
   always_comb begin
      prod_s    = cond_neg64(acc_r, neg_r);
      quo_rem_s = op_r[1] ? acc_r[2*XLEN-1:XLEN] : acc_r[XLEN-1:0];
      case (op_r)
         MD_MUL:                       fix_data_s = prod_s[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fix_data_s = prod_s[2*XLEN-1:XLEN];
         default:                      fix_data_s = cond_neg32(quo_rem_s, neg_r);
      endcase
   end

`ifdef MULDIV_EARLY_OUT_EN
   // After step cnt, the low 31-cnt bits of acc are still unconsumed multiplier bits.
   always_comb begin
      shamt_s    = 6'd31 - {1'b0, cnt_r};
      rem_mask_s = {XLEN{1'b1}} >> ({1'b0, cnt_r} + 6'd1);
      early_s    = !op_r[2] && ((step_acc_s[XLEN-1:0] & rem_mask_s) == 32'd0);
   end
`endif

   // Next-state and datapath update; flush overrides everything.
   always_comb begin
      state_nx      = state_r;
      op_nx         = op_r;
      wreg_nx       = wreg_r;
      neg_nx        = neg_r;
      acc_nx        = acc_r;
      opb_nx        = opb_r;
      cnt_nx        = cnt_r;
      resp_valid_nx = resp_valid_r;
      resp_data_nx  = resp_data_r;
      resp_wreg_nx  = resp_wreg_r;
      if (flush) begin
         state_nx      = ST_IDLE;
         resp_valid_nx = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  op_nx   = req_op_s;
                  wreg_nx = req_wreg;
                  neg_nx  = neg_req_s;
                  cnt_nx  = {CNT_W{1'b0}};
                  if (div_req_s) begin
                     acc_nx = {{XLEN{1'b0}}, abs_a_s};
                     opb_nx = abs_b_s;
                  end else begin
                     acc_nx = {{XLEN{1'b0}}, abs_b_s};
                     opb_nx = abs_a_s;
                  end
                  if (div_zero_s) begin
                     state_nx      = ST_DONE;
                     resp_valid_nx = 1'b1;
                     resp_wreg_nx  = req_wreg;
                     resp_data_nx  = req_op[1] ? req_a : 32'hFFFF_FFFF;
                  end else if (div_ovf_s) begin
                     state_nx      = ST_DONE;
                     resp_valid_nx = 1'b1;
                     resp_wreg_nx  = req_wreg;
                     resp_data_nx  = req_op[1] ? 32'd0 : 32'h8000_0000;
                  end else begin
                     state_nx = ST_CALC;
                  end
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            ST_CALC: begin
               acc_nx = step_acc_s;
`ifdef MULDIV_EARLY_OUT_EN
               if (early_s) begin
                  acc_nx   = step_acc_s >> shamt_s;
                  state_nx = ST_FIXUP;
               end else if (cnt_r == 5'd31) begin
                  state_nx = ST_FIXUP;
               end else begin
                  cnt_nx = cnt_r + 5'd1;
               end
`else
               if (cnt_r == 5'd31) begin
                  state_nx = ST_FIXUP;
               end else begin
                  cnt_nx = cnt_r + 5'd1;
               end
`endif
            end
            ST_FIXUP: begin
               resp_data_nx  = fix_data_s;
               resp_wreg_nx  = wreg_r;
               resp_valid_nx = 1'b1;
               state_nx      = ST_DONE;
            end
            ST_DONE: begin
               if (resp_ready) begin
                  state_nx      = ST_IDLE;
                  resp_valid_nx = 1'b0;
               end else begin
                  state_nx = ST_DONE;
               end
            end
            default: begin
               state_nx      = ST_IDLE;
               resp_valid_nx = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         op_r         <= MD_MUL;
         wreg_r       <= 5'd0;
         neg_r        <= 1'b0;
         acc_r        <= {(2*XLEN){1'b0}};
         opb_r        <= {XLEN{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         resp_valid_r <= 1'b0;
         resp_data_r  <= {XLEN{1'b0}};
         resp_wreg_r  <= 5'd0;
      end else begin
         state_r      <= state_nx;
         op_r         <= op_nx;
         wreg_r       <= wreg_nx;
         neg_r        <= neg_nx;
         acc_r        <= acc_nx;
         opb_r        <= opb_nx;
         cnt_r        <= cnt_nx;
         resp_valid_r <= resp_valid_nx;
         resp_data_r  <= resp_data_nx;
         resp_wreg_r  <= resp_wreg_nx;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer; expectations queued at drive time, compared at response.
// Exact latency checks apply to the default build; MULDIV_EARLY_OUT_EN adds the early-out latency test.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_wreg;
   logic        flush, busy, resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_wreg;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  wreg;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   muldiv_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_wreg   (req_wreg),
      .flush      (flush),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_wreg  (resp_wreg)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one request for the accept edge and queue its expected result.
   task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wreg, input logic [31:0] exp_data, input int exp_lat);
      exp_t e;
      e.data = exp_data;
      e.wreg = wreg;
      e.lat  = exp_lat;
      sb_q.push_back(e);
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_wreg  = wreg;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   // lat counts edges from the accept edge (1) up to the edge after which resp_valid is seen.
   task automatic wait_resp(output int lat, output bit timed_out);
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 200) begin
         step();
         lat++;
      end
      timed_out = (resp_valid !== 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
      req_wreg = 5'd0; flush = 1'b0; resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", resp_valid); else pass_cnt++;
      total_cnt++; if (resp_data !== 32'd0) $display("FAIL reset_resp_data got %h exp 0", resp_data); else pass_cnt++;
      total_cnt++; if (resp_wreg !== 5'd0) $display("FAIL reset_resp_wreg got %h exp 0", resp_wreg); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else pass_cnt++;
      rst = 1'b1;
      step();
   endtask

   task automatic test_mul();
      logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
      logic [31:0] av  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bv  [4] = '{32'd6, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF};
      logic [31:0] ev  [4] = '{32'd42, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      int lat; bit to; exp_t e;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (req_ready !== 1'b1) $display("FAIL mul_ready[%0d] got %b exp 1", i, req_ready); else pass_cnt++;
         drive_req(ops[i], av[i], bv[i], 5'(i + 1), ev[i], 34);
         wait_resp(lat, to);
         e = sb_q.pop_front();
         total_cnt++; if (to) $display("FAIL mul_timeout[%0d] got no resp_valid exp resp_valid", i); else pass_cnt++;
         total_cnt++; if (resp_data !== e.data) $display("FAIL mul_data[%0d] got %h exp %h", i, resp_data, e.data); else pass_cnt++;
         total_cnt++; if (resp_wreg !== e.wreg) $display("FAIL mul_wreg[%0d] got %0d exp %0d", i, resp_wreg, e.wreg); else pass_cnt++;
`ifndef MULDIV_EARLY_OUT_EN
         total_cnt++; if (lat != e.lat) $display("FAIL mul_latency[%0d] got T+%0d exp T+%0d", i, lat, e.lat); else pass_cnt++;
`endif
         step();
         total_cnt++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL mul_release[%0d] got ready=%b valid=%b exp ready=1 valid=0", i, req_ready, resp_valid); else pass_cnt++;
      end
   endtask

   task automatic test_div();
      logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
      logic [31:0] av  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
      logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'd2, 32'd2};
      logic [31:0] ev  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1};
      int lat; bit to; exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive_req(ops[i], av[i], bv[i], 5'(10 + i), ev[i], 34);
         wait_resp(lat, to);
         e = sb_q.pop_front();
         total_cnt++; if (to) $display("FAIL div_timeout[%0d] got no resp_valid exp resp_valid", i); else pass_cnt++;
         total_cnt++; if (resp_data !== e.data) $display("FAIL div_data[%0d] got %h exp %h", i, resp_data, e.data); else pass_cnt++;
         total_cnt++; if (resp_wreg !== e.wreg) $display("FAIL div_wreg[%0d] got %0d exp %0d", i, resp_wreg, e.wreg); else pass_cnt++;
         total_cnt++; if (lat != e.lat) $display("FAIL div_latency[%0d] got T+%0d exp T+%0d", i, lat, e.lat); else pass_cnt++;
         step();
      end
   endtask

   task automatic test_special();
      logic [2:0]  ops [5] = '{3'd4, 3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] av  [5] = '{32'd9, 32'd9, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bv  [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ev  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      int lat; bit to; exp_t e;
      for (int i = 0; i < 5; i++) begin
         drive_req(ops[i], av[i], bv[i], 5'(20 + i), ev[i], 1);
         wait_resp(lat, to);
         e = sb_q.pop_front();
         total_cnt++; if (to) $display("FAIL special_timeout[%0d] got no resp_valid exp resp_valid", i); else pass_cnt++;
         total_cnt++; if (resp_data !== e.data) $display("FAIL special_data[%0d] got %h exp %h", i, resp_data, e.data); else pass_cnt++;
         total_cnt++; if (resp_wreg !== e.wreg) $display("FAIL special_wreg[%0d] got %0d exp %0d", i, resp_wreg, e.wreg); else pass_cnt++;
         total_cnt++; if (lat != e.lat) $display("FAIL special_latency[%0d] got T+%0d exp T+%0d", i, lat, e.lat); else pass_cnt++;
         step();
      end
   endtask

   task automatic test_stall();
      int lat; bit to; exp_t e;
      resp_ready = 1'b0;
      drive_req(3'd5, 32'hFFFF_FFFF, 32'd16, 5'd17, 32'h0FFF_FFFF, 34);
      wait_resp(lat, to);
      e = sb_q.pop_front();
      total_cnt++; if (to) $display("FAIL stall_timeout got no resp_valid exp resp_valid"); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         step();
         total_cnt++; if (resp_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b exp 1", i, resp_valid); else pass_cnt++;
         total_cnt++; if (resp_data !== e.data) $display("FAIL stall_data[%0d] got %h exp %h", i, resp_data, e.data); else pass_cnt++;
         total_cnt++; if (req_ready !== 1'b0) $display("FAIL stall_ready[%0d] got %b exp 0", i, req_ready); else pass_cnt++;
      end
      resp_ready = 1'b1;
      step();
      total_cnt++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL stall_release got valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready); else pass_cnt++;
   endtask

   task automatic test_flush();
      int lat; bit to; bit seen; exp_t e;
      flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 32'd3; req_b = 32'd4; req_wreg = 5'd1;
      #1;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL flush_idle_ready got %b exp 0", req_ready); else pass_cnt++;
      step();
      flush = 1'b0; req_valid = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL flush_idle_accept got busy=%b exp 0", busy); else pass_cnt++;
      drive_req(3'd5, 32'd1000, 32'd3, 5'd8, 32'd333, 34);
      repeat (10) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      void'(sb_q.pop_front());
      total_cnt++; if (busy !== 1'b0 || resp_valid !== 1'b0)
         $display("FAIL flush_calc got busy=%b valid=%b exp busy=0 valid=0", busy, resp_valid); else pass_cnt++;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (resp_valid === 1'b1) seen = 1'b1;
      end
      total_cnt++; if (seen) $display("FAIL flush_no_resp got resp_valid=1 exp 0"); else pass_cnt++;
      drive_req(3'd0, 32'd1000, 32'd3000, 5'd9, 32'd3000000, 34);
      wait_resp(lat, to);
      e = sb_q.pop_front();
      total_cnt++; if (to || resp_data !== e.data) $display("FAIL flush_next_data got %h exp %h", resp_data, e.data); else pass_cnt++;
      total_cnt++; if (resp_wreg !== e.wreg) $display("FAIL flush_next_wreg got %0d exp %0d", resp_wreg, e.wreg); else pass_cnt++;
      step();
   endtask

   task automatic test_async_reset();
      int lat; bit to; exp_t e;
      drive_req(3'd4, 32'd100, 32'd7, 5'd30, 32'd14, 34);
      repeat (5) step();
      #2 rst = 1'b0;
      #1;
      sb_q.delete();
      total_cnt++; if (busy !== 1'b0) $display("FAIL arst_busy got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (resp_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", resp_valid); else pass_cnt++;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL arst_ready got %b exp 1", req_ready); else pass_cnt++;
      total_cnt++; if (resp_data !== 32'd0) $display("FAIL arst_data got %h exp 0", resp_data); else pass_cnt++;
      total_cnt++; if (resp_wreg !== 5'd0) $display("FAIL arst_wreg got %0d exp 0", resp_wreg); else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      step();
      drive_req(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 34);
      wait_resp(lat, to);
      e = sb_q.pop_front();
      total_cnt++; if (to || resp_data !== e.data) $display("FAIL arst_next_data got %h exp %h", resp_data, e.data); else pass_cnt++;
      step();
   endtask

`ifdef MULDIV_EARLY_OUT_EN
   task automatic test_early_out();
      int lat; bit to; exp_t e;
      drive_req(3'd0, 32'h0001_2345, 32'd1, 5'd12, 32'h0001_2345, 3);
      wait_resp(lat, to);
      e = sb_q.pop_front();
      total_cnt++; if (to || resp_data !== e.data) $display("FAIL early_data got %h exp %h", resp_data, e.data); else pass_cnt++;
      total_cnt++; if (lat != e.lat) $display("FAIL early_latency got T+%0d exp T+%0d", lat, e.lat); else pass_cnt++;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_stall();
      test_flush();
      test_async_reset();
`ifdef MULDIV_EARLY_OUT_EN
      test_early_out();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion exp completion before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit beside the execute-stage ALU. Serves the MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU ops.
- Accepts one request from decode/execute over a valid/ready handshake and runs a 32-step shift-add or restoring-divide sequence.
- Holds `busy` high so the pipeline stalls, then presents the 32-bit result and writeback register to the memory/writeback stage.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width, equal to $clog2(XLEN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  MdOp from Common; encoding equals funct3 (MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7).
- req_a  in  32  rs1 value.
- req_b  in  32  rs2 value.
- req_wreg  in  5  destination register.
- flush  in  1  kill the in-flight op (branch mispredict or trap).
- busy  out  1  state != IDLE; drives the pipeline stall.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  result.
- resp_wreg  out  5  destination register echoed from the request.

Behaviour:
- Reset: state=IDLE, resp_valid=0, resp_data=0, resp_wreg=0, counter=0, busy=0, req_ready=1. Reset mid-operation discards the op entirely.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - Accept when req_valid && req_ready.
  - Latch op and wreg; latch |a| and |b| per signedness (MULH: both signed; MULHSU: a signed only; DIV/REM signed; the rest unsigned).
  - Latch result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Special cases go directly to DONE (next-cycle result):
    - b==0 on DIV/DIVU: quotient = 0xFFFFFFFF.
    - b==0 on REM/REMU: remainder = a.
    - DIV with a=0x80000000, b=0xFFFFFFFF: quotient = 0x80000000; REM gives 0.
  - Otherwise go to CALC with counter=0.
- CALC, one step per cycle, counter increments; leave after counter==31 (32 steps) to FIXUP:
  - Multiply: 64-bit accumulator; add the multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: restoring divide; shift the remainder left, trial-subtract a 33-bit value, set the quotient bit on no borrow.
- FIXUP (1 cycle):
  - Apply the two's-complement sign to the 64-bit product or to the quotient/remainder.
  - Select low or high product word.
  - Register resp_data and resp_wreg; go to DONE.
- DONE:
  - resp_valid=1 and held stable until resp_ready; then IDLE with resp_valid=0 on the same edge.
  - resp_ready low stalls indefinitely with resp_data unchanged.
- Latency (normal op, resp_ready tied 1): accept edge T; resp_valid visible in cycle T+34; req_ready high again at T+35. Special case: resp_valid at T+1.
- flush: in any state, next edge → IDLE and resp_valid=0. flush in IDLE has no effect, and a request in the same cycle as flush is not accepted (req_ready is forced 0 while flush=1).
- No back-to-back acceptance: a new request is accepted only in IDLE.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined:
  - Multiply leaves CALC as soon as the remaining multiplier bits are all zero; the accumulator is shifted by the remaining count in one cycle.
  - Minimum multiply latency is FIXUP+DONE after at least 1 CALC step.
  - Divide is unchanged.
- Undefined: fixed 32 CALC cycles for every non-special op; the bench checks exact latency only in this mode.

Decomposition:
- Common package: MdOp enum (funct3 encoding), MdState enum, XLEN constant.
- One sub-module, muldiv_step: combinational single iteration (multiply add/shift and divide trial-subtract), instantiated once inside muldiv_sequencer.

Test Plan:
- MUL a=7, b=6 → resp_data=42, wreg echoed, resp_valid exactly at T+34 (feature off).
- MULH a=0x80000000, b=0x80000000 → 0x40000000; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF; MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE.
- DIV a=-7, b=2 → -3; REM → -1; DIVU a=7, b=2 → 3; REMU → 1.
- DIV by 0 → 0xFFFFFFFF at T+1; REM a=5, b=0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- resp_ready held low 5 cycles in DONE → resp_valid and resp_data stable, req_ready=0; flush at CALC step 10 → IDLE next edge, no resp_valid, next request correct.
- rst pulsed low mid-CALC (asynchronous, between edges) → outputs at reset values immediately; MUL with b=1 and MULDIV_EARLY_OUT_EN defined → resp_valid at T+3.
